// File: rtl/memory_write_scheduler.sv
// memory_write_scheduler: round-robin front end that splits channel write requests into bounded, boundary-safe chunks
// Ports: clock, reset (async, active-high); ch_addr/ch_len/ch_start carry one request per channel (channel i at slice i);
// ch_busy/ch_done/ch_error return per-channel status; m_addr/m_len/m_start issue chunks to the write engine,
// which reports back on m_busy/m_done/m_error.
module memory_write_scheduler #(
    parameter int NUM_CHANNELS   = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int MAX_CHUNK      = 256,
    parameter int BOUNDARY       = 4096,
    parameter bit ABORT_ON_ERROR = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CHANNELS*LEN_WIDTH-1:0]  ch_len,
    input  logic [NUM_CHANNELS-1:0]            ch_start,
    output logic [NUM_CHANNELS-1:0]            ch_busy,
    output logic [NUM_CHANNELS-1:0]            ch_done,
    output logic [NUM_CHANNELS-1:0]            ch_error,
    output logic [ADDR_WIDTH-1:0]              m_addr,
    output logic [LEN_WIDTH-1:0]               m_len,
    output logic                               m_start,
    input  logic                               m_busy,
    input  logic                               m_done,
    input  logic                               m_error
);
    localparam int PW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int CW = LEN_WIDTH + 1;
    localparam int WW = (ADDR_WIDTH > LEN_WIDTH ? ADDR_WIDTH : LEN_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   pend_addr [NUM_CHANNELS];
    logic [LEN_WIDTH-1:0]    pend_len  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pend_err, accept, cand;
    logic [PW-1:0]           rr_ptr, grant, sel;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    rem, rem_left;
    logic [CW-1:0]           cap, chunk;
    logic [WW-1:0]           room;
    logic                    err_new, issue, adv, fin;

    // Requests being captured this cycle already count as pending, so the
    // arbiter can grant in the capture cycle and the first chunk starts two
    // cycles after ch_start.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            accept[i] = ch_start[i] & ~ch_busy[i];
            cand[i]   = ch_busy[i] | (accept[i] & (ch_len[i*LEN_WIDTH +: LEN_WIDTH] != '0));
        end
    end

    // Scanning downwards lets the candidate closest to rr_ptr win.
    always_comb begin
        sel = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--)
            if (cand[(int'(rr_ptr) + k) % NUM_CHANNELS]) sel = PW'((int'(rr_ptr) + k) % NUM_CHANNELS);
    end

    assign cur_addr = pend_addr[grant];
    assign rem      = pend_len[grant];
    assign cap      = ({1'b0, rem} < CW'(MAX_CHUNK)) ? {1'b0, rem} : CW'(MAX_CHUNK);
    assign room     = WW'(BOUNDARY) - WW'(cur_addr & ADDR_WIDTH'(BOUNDARY - 1));
    assign chunk    = (room < WW'(cap)) ? CW'(room) : cap;
    assign rem_left = rem - chunk[LEN_WIDTH-1:0];
    assign err_new  = pend_err[grant] | m_error;

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // The pointer advance and completion decision are taken on m_done so that
    // ch_done lands one cycle after m_done; NEXT is the issue attempt for the
    // following chunk of the same grant.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: state_n = |cand ? ISSUE : IDLE;
            ISSUE, NEXT: begin
                issue   = !m_busy;
                state_n = issue ? WAIT : ISSUE;
            end
            WAIT: begin
                adv     = m_done;
                fin     = m_done && (rem_left == '0 || (ABORT_ON_ERROR && err_new));
                state_n = fin ? IDLE : m_done ? NEXT : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant    <= '0;
            pend_err <= '0;
            ch_busy  <= '0;
            ch_done  <= '0;
            ch_error <= '0;
            m_start  <= 1'b0;
            m_addr   <= '0;
            m_len    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pend_addr[i] <= '0;
                pend_len[i]  <= '0;
            end
        end else begin
            ch_done <= '0;
            m_start <= issue;
            for (int i = 0; i < NUM_CHANNELS; i++)
                if (accept[i]) begin
                    pend_addr[i] <= ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    pend_len[i]  <= ch_len[i*LEN_WIDTH +: LEN_WIDTH];
                    pend_err[i]  <= 1'b0;
                    ch_error[i]  <= 1'b0;
                    ch_busy[i]   <= cand[i];
                    ch_done[i]   <= !cand[i];
                end
            if (state == IDLE) grant <= sel;
            if (issue) begin
                m_addr <= cur_addr;
                m_len  <= chunk[LEN_WIDTH-1:0];
            end
            if (adv) begin
                pend_addr[grant] <= cur_addr + ADDR_WIDTH'(chunk);
                pend_len[grant]  <= rem_left;
                pend_err[grant]  <= err_new;
            end
            if (fin) begin
                ch_busy[grant]  <= 1'b0;
                ch_done[grant]  <= 1'b1;
                ch_error[grant] <= err_new;
                rr_ptr          <= grant == PW'(NUM_CHANNELS - 1) ? '0 : grant + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_memory_write_scheduler.sv
// tb_memory_write_scheduler: scoreboard bench for memory_write_scheduler
module tb_memory_write_scheduler;
    localparam int N = 4, AW = 32, LW = 16;

    typedef struct { logic [AW-1:0] a; logic [LW-1:0] l; } mtx_t;
    typedef struct { int ch; logic err; } done_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*AW-1:0] ch_addr;
    logic [N*LW-1:0] ch_len;
    logic [N-1:0]    ch_start, ch_busy, ch_done, ch_error;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic            m_start, m_busy, m_done, m_error;

    logic [N*AW-1:0] b_ch_addr;
    logic [N*LW-1:0] b_ch_len;
    logic [N-1:0]    b_ch_start, b_ch_busy, b_ch_done, b_ch_error;
    logic [AW-1:0]   b_m_addr;
    logic [LW-1:0]   b_m_len;
    logic            b_m_start, b_m_busy, b_m_done, b_m_error;

    mtx_t  exp_m[$];
    done_t exp_d[$];
    int    ms_cyc[$], md_cyc[$], cd_cyc[$];
    int    cyc = 0, n_chk = 0, n_fail = 0, nchunk = 0;
    logic [31:0] err_mask = '0;

    always #5 clock = ~clock;

    memory_write_scheduler #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_CHUNK(256),
                             .BOUNDARY(4096), .ABORT_ON_ERROR(1)) dut (
        .clock(clock), .reset(reset), .ch_addr(ch_addr), .ch_len(ch_len), .ch_start(ch_start),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_error(ch_error), .m_addr(m_addr), .m_len(m_len),
        .m_start(m_start), .m_busy(m_busy), .m_done(m_done), .m_error(m_error));

    memory_write_scheduler #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_CHUNK(256),
                             .BOUNDARY(4096), .ABORT_ON_ERROR(0)) dut_noabort (
        .clock(clock), .reset(reset), .ch_addr(b_ch_addr), .ch_len(b_ch_len), .ch_start(b_ch_start),
        .ch_busy(b_ch_busy), .ch_done(b_ch_done), .ch_error(b_ch_error), .m_addr(b_m_addr), .m_len(b_m_len),
        .m_start(b_m_start), .m_busy(b_m_busy), .m_done(b_m_done), .m_error(b_m_error));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -999;
    endfunction

    task automatic set(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l);
        ch_addr[ch*AW +: AW] = a;
        ch_len[ch*LW +: LW]  = l;
    endtask

    task automatic go(input logic [N-1:0] m);
        ch_start = m;
        @(posedge clock); #1;
        ch_start = '0;
    endtask

    task automatic clr();
        ms_cyc.delete(); md_cyc.delete(); cd_cyc.delete();
        nchunk = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((ch_busy != '0 || exp_d.size() != 0) && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        chk({nm, "_timeout"}, n < 300, 1);
        repeat (2) begin @(posedge clock); #1; end
    endtask

    // Write engine model: busy from m_start, m_done two cycles later, error per err_mask bit.
    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_error = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (m_start) begin
                m_busy = 1'b1;
                repeat (2) begin @(posedge clock); #1; end
                m_done  = 1'b1;
                m_error = err_mask[nchunk];
                nchunk++;
                @(posedge clock); #1;
                {m_busy, m_done, m_error} = '0;
            end
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : mon
        mtx_t e;
        done_t d;
        if (!reset) begin
            if (m_done) md_cyc.push_back(cyc);
            if (m_start) begin
                ms_cyc.push_back(cyc);
                chk("m_start_expected", exp_m.size() != 0, 1);
                if (exp_m.size() != 0) begin
                    e = exp_m.pop_front();
                    chk("m_addr", m_addr, e.a);
                    chk("m_len", m_len, e.l);
                end
            end
            for (int i = 0; i < N; i++)
                if (ch_done[i]) begin
                    cd_cyc.push_back(cyc);
                    chk("ch_done_expected", exp_d.size() != 0, 1);
                    if (exp_d.size() != 0) begin
                        d = exp_d.pop_front();
                        chk("ch_done_channel", i, d.ch);
                        chk("ch_error_at_done", ch_error[i], d.err);
                    end
                end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ns;
        logic seen, e;
        logic [AW-1:0] last_a;
        logic [LW-1:0] last_l;
        reset = 1'b1;
        ch_addr = '0; ch_len = '0; ch_start = '0;
        b_ch_addr = '0; b_ch_len = '0; b_ch_start = '0;
        b_m_busy = 1'b0; b_m_done = 1'b0; b_m_error = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ch_busy", ch_busy, 0);
        chk("rst_ch_done", ch_done, 0);
        chk("rst_ch_error", ch_error, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_len", m_len, 0);

        // single request
        clr();
        set(0, 32'h1000, 16'd64);
        exp_m.push_back('{32'h1000, 16'd64});
        exp_d.push_back('{0, 1'b0});
        go(4'b0001);
        chk("s1_busy_t1", ch_busy[0], 1);
        chk("s1_no_start_t1", m_start, 0);
        @(posedge clock); #1;
        chk("s1_start_t2", m_start, 1);
        wait_idle("s1");
        chk("s1_done_latency", qat(cd_cyc, 0) - qat(md_cyc, 0), 1);
        chk("s1_error_held", ch_error[0], 0);

        // 4 KiB boundary split
        clr();
        set(1, 32'h0FF0, 16'h40);
        exp_m.push_back('{32'h0FF0, 16'h10});
        exp_m.push_back('{32'h1000, 16'h30});
        exp_d.push_back('{1, 1'b0});
        go(4'b0010);
        wait_idle("s2");
        chk("s2_chunk_gap", qat(ms_cyc, 1) - qat(md_cyc, 0), 2);
        chk("s2_done_latency", qat(cd_cyc, 0) - qat(md_cyc, 1), 1);
        chk("s2_single_done", cd_cyc.size(), 1);

        // MAX_CHUNK split
        clr();
        set(2, 32'h2000, 16'd600);
        exp_m.push_back('{32'h2000, 16'd256});
        exp_m.push_back('{32'h2100, 16'd256});
        exp_m.push_back('{32'h2200, 16'd88});
        exp_d.push_back('{2, 1'b0});
        go(4'b0100);
        wait_idle("s3");
        chk("s3_chunk_count", ms_cyc.size(), 3);

        // round robin from rr_ptr=0
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        clr();
        for (int i = 0; i < N; i++) begin
            set(i, 32'h4000 + 32'h100 * i, 16'd16);
            exp_m.push_back('{32'h4000 + 32'h100 * i, 16'd16});
            exp_d.push_back('{i, 1'b0});
        end
        go(4'b1111);
        chk("s4_all_busy", ch_busy, 4'hF);
        wait_idle("s4");
        for (int k = 0; k < 3; k++) chk("s4_b2b_gap", qat(ms_cyc, k + 1) - qat(md_cyc, k), 3);
        clr();
        exp_m.push_back('{32'h4000, 16'd16});
        exp_m.push_back('{32'h4200, 16'd16});
        exp_d.push_back('{0, 1'b0});
        exp_d.push_back('{2, 1'b0});
        go(4'b0101);
        wait_idle("s4b");

        // error on second chunk with abort
        clr();
        err_mask = 32'h2;
        set(3, 32'h8000, 16'd600);
        exp_m.push_back('{32'h8000, 16'd256});
        exp_m.push_back('{32'h8100, 16'd256});
        exp_d.push_back('{3, 1'b1});
        go(4'b1000);
        wait_idle("s5");
        chk("s5_chunks_before_abort", ms_cyc.size(), 2);
        repeat (3) begin @(posedge clock); #1; end
        chk("s5_error_hold", ch_error[3], 1);
        clr();
        err_mask = '0;
        set(3, 32'hA000, 16'd16);
        exp_m.push_back('{32'hA000, 16'd16});
        exp_d.push_back('{3, 1'b0});
        go(4'b1000);
        chk("s5_error_clear", ch_error[3], 0);
        wait_idle("s5b");

        // zero length request
        clr();
        set(1, 32'h5000, 16'd0);
        exp_d.push_back('{1, 1'b0});
        go(4'b0010);
        chk("s6_len0_done", ch_done[1], 1);
        chk("s6_len0_not_busy", ch_busy[1], 0);
        @(posedge clock); #1;
        chk("s6_len0_done_pulse", ch_done[1], 0);
        repeat (3) begin @(posedge clock); #1; end
        chk("s6_len0_no_chunk", ms_cyc.size(), 0);

        // reset while waiting for the engine
        clr();
        set(0, 32'h9000, 16'd64);
        exp_m.push_back('{32'h9000, 16'd64});
        go(4'b0001);
        n = 0;
        while (!m_start && n < 20) begin @(posedge clock); #1; n++; end
        chk("s7_start_seen", m_start, 1);
        chk("s7_start_addr", m_addr, 32'h9000);
        exp_m.delete();
        #1 reset = 1'b1;
        #1;
        chk("s7_rst_busy", ch_busy, 0);
        chk("s7_rst_m_start", m_start, 0);
        chk("s7_rst_m_addr", m_addr, 0);
        chk("s7_rst_m_len", m_len, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        chk("s7_late_done_seen", md_cyc.size(), 1);
        chk("s7_no_ch_done", cd_cyc.size(), 0);
        chk("s7_no_restart", ms_cyc.size(), 0);
        chk("s7_idle_busy", ch_busy, 0);

        // error without abort on the second instance
        b_ch_len[LW-1:0] = 16'd600;
        b_ch_start = 4'b0001;
        @(posedge clock); #1;
        b_ch_start = '0;
        n = 0; ns = 0; seen = 1'b0; e = 1'b0; last_a = '0; last_l = '0;
        while (!seen && n < 100) begin
            @(posedge clock); #1;
            n++;
            {b_m_done, b_m_error} = '0;
            if (b_ch_done[0]) begin seen = 1'b1; e = b_ch_error[0]; end
            if (b_m_start) begin
                ns++;
                last_a = b_m_addr;
                last_l = b_m_len;
                b_m_done = 1'b1;
                b_m_error = (ns == 2);
            end
        end
        chk("s8_done_seen", seen, 1);
        chk("s8_chunk_count", ns, 3);
        chk("s8_error", e, 1);
        chk("s8_last_addr", last_a, 32'h200);
        chk("s8_last_len", last_l, 16'd88);

        chk("exp_m_drained", exp_m.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_write_scheduler.md
# memory_write_scheduler

Multi-channel front end for a single AXI memory write engine. It accepts write requests from NUM_CHANNELS independent masters and arbitrates between them round-robin. Each request is split into downstream chunks that never exceed MAX_CHUNK bytes and never cross a BOUNDARY-aligned address. Per-channel busy/done/error status is returned with the same semantics the write engine itself provides.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of upstream request channels (≥1).
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 16, byte length width.
- MAX_CHUNK, 256, maximum bytes per downstream transaction. Must satisfy 1 ≤ MAX_CHUNK ≤ BOUNDARY and MAX_CHUNK ≤ 2^LEN_WIDTH-1.
- BOUNDARY, 4096, power of two; no chunk crosses a multiple of it.
- ABORT_ON_ERROR, 1, 1 = drop the remaining chunks of a request after an errored chunk.

Ports (upstream vectors flattened, channel i at slice i):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ch_addr  in  NUM_CHANNELS*ADDR_WIDTH  request start address.
- ch_len  in  NUM_CHANNELS*LEN_WIDTH  request length in bytes.
- ch_start  in  NUM_CHANNELS  one-cycle request pulse.
- ch_busy  out  NUM_CHANNELS  request accepted and not yet complete.
- ch_done  out  NUM_CHANNELS  one-cycle completion pulse.
- ch_error  out  NUM_CHANNELS  request error status; valid while ch_done=1.
- m_addr  out  ADDR_WIDTH  chunk address to the write engine.
- m_len  out  LEN_WIDTH  chunk length to the write engine.
- m_start  out  1  one-cycle chunk start.
- m_busy  in  1  write engine busy.
- m_done  in  1  write engine chunk complete.
- m_error  in  1  chunk error; sampled with m_done.

## Operation
- Per channel: pending register holding addr, remaining len and a sticky error bit.
- ch_start[i] with ch_busy[i]=0 captures ch_addr/ch_len; ch_busy[i]=1 from the next cycle.
- ch_start[i] with ch_busy[i]=1 is ignored.
- Request with len=0 is not scheduled. ch_done[i] pulses the cycle after ch_start, ch_error=0, ch_busy stays 0.
- ch_error[i] holds its value after ch_done until the next accepted ch_start[i].
- FSM states: IDLE, ISSUE, WAIT, NEXT.
  - IDLE: if any channel is pending, grant the first pending channel at or after rr_ptr (wrapping); go to ISSUE.
  - ISSUE: wait for m_busy=0. Then drive m_start=1 for one cycle with m_addr=cur addr and m_len=chunk; go to WAIT.
  - WAIT: on m_done, OR m_error into the sticky error bit; go to NEXT.
  - NEXT: addr += chunk (modulo 2^ADDR_WIDTH); remaining -= chunk.
    - If remaining=0, or (ABORT_ON_ERROR and error): complete the request, set rr_ptr = grant+1 mod NUM_CHANNELS, go to IDLE.
    - Otherwise go to ISSUE with the same grant. A request is never preempted mid-way.
- chunk = min(remaining, MAX_CHUNK, BOUNDARY - (addr mod BOUNDARY)), computed at LEN_WIDTH+1 bits internally.
- Completion: ch_done[grant]=1 for one cycle, ch_error[grant]=sticky error, ch_busy[grant]=0 in the same cycle.
- ch_start for the channel currently in service is ignored, because its busy=1.
- m_addr/m_len are held stable from m_start until the cycle after m_done.
- m_done outside WAIT is ignored.

## Timing
- Reset: IDLE, rr_ptr=0, all pending cleared; ch_busy=0, ch_done=0, ch_error=0, m_start=0, m_addr=0, m_len=0.
- Reset mid-transfer discards all requests. Any downstream transaction still outstanding is not tracked; a following m_done is ignored.
- All outputs are registered.
- Single request, idle block, m_busy=0:
  - ch_start at t, ch_busy at t+1.
  - m_start at t+2.
  - m_done at d, so ch_done at d+1, or the next chunk's m_start at d+2.
- Back-to-back requests from different channels: next m_start no earlier than d+3.
- Simultaneous ch_start on several channels: all are captured in the same cycle; service order follows rr_ptr.
- Channel i may restart in the cycle after its ch_done pulse.

## Test plan
- Single request, ch0 addr=0x1000, len=64: one m_start with addr 0x1000, len 64. ch_done[0] one cycle after m_done, ch_error=0.
- Boundary split, addr=0x0FF0, len=0x40: chunks (0x0FF0, 0x10) then (0x1000, 0x30); exactly one ch_done.
- MAX_CHUNK split, addr=0x2000, len=600: chunks 256@0x2000, 256@0x2100, 88@0x2200.
- Round-robin, all four channels start in the same cycle with len=16, rr_ptr=0: service order 0,1,2,3. Then ch0 and ch2 restart together: service order 0,2.
- Error, len=600, m_error=1 on chunk 1:
  - ABORT_ON_ERROR=1: no further m_start; ch_done with ch_error=1.
  - ABORT_ON_ERROR=0: three chunks issued; ch_error=1.
- len=0 request, then reset asserted during WAIT of another request: len=0 gives ch_done the next cycle with no m_start. Reset returns all outputs to 0; a late m_done is ignored.
